// File: rtl/cluster_pwr_seq_ctrl.sv
// Cluster power-domain sequencer: orders power switch, isolation clamp, clock enable and
// cluster reset around a 4-phase PMU req/ack handshake. Lives entirely in the always-on domain.

module cluster_pwr_seq_ctrl_chk (
    input  logic clk,
    input  logic rst_n,
    input  logic pwr_ack,
    input  logic busy,
    input  logic switch_en,
    input  logic iso_en,
    input  logic clk_en,
    input  logic cluster_rst_n
);

    // Clamps may only open in ON, which is the sole state with ack high and busy low
    a_iso_only_on: assert property (@(posedge clk) disable iff (!rst_n)
        (!iso_en |-> (pwr_ack && !busy)));

    a_clk_needs_power: assert property (@(posedge clk) disable iff (!rst_n)
        (clk_en |-> switch_en));

    // RST_REL, ON and ISO_SET all run with clock and power up
    a_rst_rel_window: assert property (@(posedge clk) disable iff (!rst_n)
        (cluster_rst_n |-> (clk_en && switch_en)));

    a_iso_when_unpowered: assert property (@(posedge clk) disable iff (!rst_n)
        (!switch_en |-> iso_en));

endmodule

module cluster_pwr_seq_ctrl #(
    parameter int SETTLE_CYCLES  = 16,
    parameter int RST_CYCLES     = 8,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic pwr_req_i,
    output logic pwr_ack_o,
    output logic busy_o,
    output logic switch_en_o,
    input  logic switch_ack_i,
    output logic iso_en_o,
    output logic clk_en_o,
    output logic cluster_rst_no,
    output logic timeout_o
);

    localparam int MAX_SR  = (SETTLE_CYCLES > RST_CYCLES) ? SETTLE_CYCLES : RST_CYCLES;
    localparam int MAX_CYC = (MAX_SR > TIMEOUT_CYCLES) ? MAX_SR : TIMEOUT_CYCLES;
    localparam int CNT_W   = $clog2(MAX_CYC) + 1;

    localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] RST_LOAD    = CNT_W'(RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] TMO_LOAD    = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ZERO    = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE     = {{(CNT_W-1){1'b0}}, 1'b1};

    typedef enum logic [3:0] {
        ST_OFF     = 4'd0,
        ST_PWR_UP  = 4'd1,
        ST_SETTLE  = 4'd2,
        ST_CLK_ON  = 4'd3,
        ST_RST_REL = 4'd4,
        ST_ON      = 4'd5,
        ST_ISO_SET = 4'd6,
        ST_RST_SET = 4'd7,
        ST_CLK_OFF = 4'd8,
        ST_PWR_DN  = 4'd9
    } state_t;

    typedef struct packed {
        logic pwr_ack;
        logic busy;
        logic switch_en;
        logic iso_en;
        logic clk_en;
        logic cluster_rst_n;
    } outs_t;

    localparam outs_t OUTS_OFF = '{pwr_ack: 1'b0, busy: 1'b0, switch_en: 1'b0,
                                   iso_en: 1'b1, clk_en: 1'b0, cluster_rst_n: 1'b0};

    // Output pattern held while resident in a state; registered on state entry
    function automatic outs_t state_outs(input state_t st);
        outs_t o;
        o = OUTS_OFF;
        case (st)
            ST_OFF: begin
                o = OUTS_OFF;
            end
            ST_PWR_UP, ST_SETTLE: begin
                o.busy      = 1'b1;
                o.switch_en = 1'b1;
            end
            ST_CLK_ON: begin
                o.busy      = 1'b1;
                o.switch_en = 1'b1;
                o.clk_en    = 1'b1;
            end
            ST_RST_REL: begin
                o.busy          = 1'b1;
                o.switch_en     = 1'b1;
                o.clk_en        = 1'b1;
                o.cluster_rst_n = 1'b1;
            end
            ST_ON: begin
                o.pwr_ack       = 1'b1;
                o.switch_en     = 1'b1;
                o.iso_en        = 1'b0;
                o.clk_en        = 1'b1;
                o.cluster_rst_n = 1'b1;
            end
            ST_ISO_SET: begin
                o.pwr_ack       = 1'b1;
                o.busy          = 1'b1;
                o.switch_en     = 1'b1;
                o.clk_en        = 1'b1;
                o.cluster_rst_n = 1'b1;
            end
            ST_RST_SET: begin
                o.pwr_ack   = 1'b1;
                o.busy      = 1'b1;
                o.switch_en = 1'b1;
                o.clk_en    = 1'b1;
            end
            ST_CLK_OFF: begin
                o.pwr_ack   = 1'b1;
                o.busy      = 1'b1;
                o.switch_en = 1'b1;
            end
            ST_PWR_DN: begin
                o.busy = 1'b1;
            end
            default: begin
                o = OUTS_OFF;
            end
        endcase
        return o;
    endfunction

    state_t             state_r;
    logic [CNT_W-1:0]   cnt_r;
    outs_t              outs_r;
    logic               timeout_r;
    logic               ack_meta_r;
    logic               ack_sync_r;
    logic               cnt_zero_s;
    logic [CNT_W-1:0]   cnt_dec_s;

    assign cnt_zero_s = (cnt_r == CNT_ZERO);
    assign cnt_dec_s  = cnt_r - CNT_ONE;

    // Two-flop synchroniser for the asynchronous switch-chain acknowledge
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ack_meta_r <= 1'b0;
            ack_sync_r <= 1'b0;
        end else begin
            ack_meta_r <= switch_ack_i;
            ack_sync_r <= ack_meta_r;
        end
    end

    // Sequencer FSM: counter loads on state entry and counts down to zero
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_r   <= ST_OFF;
            cnt_r     <= CNT_ZERO;
            outs_r    <= OUTS_OFF;
            timeout_r <= 1'b0;
        end else begin
            case (state_r)
                ST_OFF: begin
                    if (pwr_req_i) begin
                        state_r <= ST_PWR_UP;
                        cnt_r   <= TMO_LOAD;
                        outs_r  <= state_outs(ST_PWR_UP);
                    end
                end
                ST_PWR_UP: begin
                    if (ack_sync_r) begin
                        state_r <= ST_SETTLE;
                        cnt_r   <= SETTLE_LOAD;
                        outs_r  <= state_outs(ST_SETTLE);
                    end else if (cnt_zero_s) begin
                        // Switch chain never confirmed: back the domain out safely
                        timeout_r <= 1'b1;
                        state_r   <= ST_PWR_DN;
                        cnt_r     <= TMO_LOAD;
                        outs_r    <= state_outs(ST_PWR_DN);
                    end else begin
                        cnt_r <= cnt_dec_s;
                    end
                end
                ST_SETTLE: begin
                    if (cnt_zero_s) begin
                        state_r <= ST_CLK_ON;
                        cnt_r   <= RST_LOAD;
                        outs_r  <= state_outs(ST_CLK_ON);
                    end else begin
                        cnt_r <= cnt_dec_s;
                    end
                end
                ST_CLK_ON: begin
                    if (cnt_zero_s) begin
                        state_r <= ST_RST_REL;
                        cnt_r   <= CNT_ZERO;
                        outs_r  <= state_outs(ST_RST_REL);
                    end else begin
                        cnt_r <= cnt_dec_s;
                    end
                end
                ST_RST_REL: begin
                    state_r <= ST_ON;
                    outs_r  <= state_outs(ST_ON);
                end
                ST_ON: begin
                    if (!pwr_req_i) begin
                        state_r <= ST_ISO_SET;
                        outs_r  <= state_outs(ST_ISO_SET);
                    end
                end
                ST_ISO_SET: begin
                    state_r <= ST_RST_SET;
                    outs_r  <= state_outs(ST_RST_SET);
                end
                ST_RST_SET: begin
                    state_r <= ST_CLK_OFF;
                    outs_r  <= state_outs(ST_CLK_OFF);
                end
                ST_CLK_OFF: begin
                    state_r <= ST_PWR_DN;
                    cnt_r   <= TMO_LOAD;
                    outs_r  <= state_outs(ST_PWR_DN);
                end
                ST_PWR_DN: begin
                    if (!ack_sync_r) begin
                        state_r <= ST_OFF;
                        cnt_r   <= CNT_ZERO;
                        outs_r  <= state_outs(ST_OFF);
                    end else if (cnt_zero_s) begin
                        timeout_r <= 1'b1;
                        state_r   <= ST_OFF;
                        cnt_r     <= CNT_ZERO;
                        outs_r    <= state_outs(ST_OFF);
                    end else begin
                        cnt_r <= cnt_dec_s;
                    end
                end
                default: begin
                    state_r <= ST_OFF;
                    cnt_r   <= CNT_ZERO;
                    outs_r  <= OUTS_OFF;
                end
            endcase
        end
    end

    assign pwr_ack_o      = outs_r.pwr_ack;
    assign busy_o         = outs_r.busy;
    assign switch_en_o    = outs_r.switch_en;
    assign iso_en_o       = outs_r.iso_en;
    assign clk_en_o       = outs_r.clk_en;
    assign cluster_rst_no = outs_r.cluster_rst_n;
    assign timeout_o      = timeout_r;

    cluster_pwr_seq_ctrl_chk u_chk (
        .clk           (clk_i),
        .rst_n         (rst_ni),
        .pwr_ack       (pwr_ack_o),
        .busy          (busy_o),
        .switch_en     (switch_en_o),
        .iso_en        (iso_en_o),
        .clk_en        (clk_en_o),
        .cluster_rst_n (cluster_rst_no)
    );

endmodule

// File: tb/tb_cluster_pwr_seq_ctrl.sv
// Scoreboard bench for cluster_pwr_seq_ctrl: expected output vectors are queued with the
// cycle they are due and popped when that cycle is reached.

module tb_cluster_pwr_seq_ctrl;

    logic clk = 1'b0;
    logic rst_n;
    logic pwr_req;
    logic switch_ack;
    logic pwr_ack, busy, switch_en, iso_en, clk_en, cluster_rst_n, timeout;

    cluster_pwr_seq_ctrl dut (
        .clk_i          (clk),
        .rst_ni         (rst_n),
        .pwr_req_i      (pwr_req),
        .pwr_ack_o      (pwr_ack),
        .busy_o         (busy),
        .switch_en_o    (switch_en),
        .switch_ack_i   (switch_ack),
        .iso_en_o       (iso_en),
        .clk_en_o       (clk_en),
        .cluster_rst_no (cluster_rst_n),
        .timeout_o      (timeout)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // {pwr_ack, busy, switch_en, iso_en, clk_en, cluster_rst_n}
    localparam logic [5:0] V_OFF    = 6'b000100;
    localparam logic [5:0] V_UP     = 6'b011100;
    localparam logic [5:0] V_CLKON  = 6'b011110;
    localparam logic [5:0] V_RSTREL = 6'b011111;
    localparam logic [5:0] V_ON     = 6'b101011;
    localparam logic [5:0] V_ISO    = 6'b111111;
    localparam logic [5:0] V_RSTSET = 6'b111110;
    localparam logic [5:0] V_CLKOFF = 6'b111100;
    localparam logic [5:0] V_DN     = 6'b010100;

    typedef struct packed {
        int         at;
        logic [6:0] val;
    } exp_t;

    exp_t  sb_q[$];
    string nm_q[$];
    int    checks = 0;
    int    failures = 0;

    logic [6:0] obs;
    assign obs = {pwr_ack, busy, switch_en, iso_en, clk_en, cluster_rst_n, timeout};

    task automatic push(input int at, input logic [5:0] v, input logic t, input string nm);
        exp_t e;
        e.at  = at;
        e.val = {v, t};
        sb_q.push_back(e);
        nm_q.push_back(nm);
    endtask

    task automatic test_reset();
        exp_t e;
        string nm;
        rst_n = 1'b0;
        pwr_req = 1'b0;
        switch_ack = 1'b0;
        repeat (3) @(negedge clk);
        push(cyc, V_OFF, 1'b0, "reset_state");
        e = sb_q.pop_front();
        nm = nm_q.pop_front();
        checks++;
        if (obs !== e.val) begin
            failures++;
            $display("FAIL %s cyc=%0d got=%b exp=%b", nm, cyc, obs, e.val);
        end
        rst_n = 1'b1;
        @(negedge clk);
        push(cyc + 2, V_OFF, 1'b0, "idle_after_reset");
        for (int k = 0; k < 10 && sb_q.size() > 0; k++) begin
            @(negedge clk);
            if (sb_q[0].at == cyc) begin
                e = sb_q.pop_front();
                nm = nm_q.pop_front();
                checks++;
                if (obs !== e.val) begin
                    failures++;
                    $display("FAIL %s cyc=%0d got=%b exp=%b", nm, cyc, obs, e.val);
                end
            end
        end
    endtask

    task automatic test_power_up();
        exp_t e;
        string nm;
        int c0;
        @(negedge clk);
        pwr_req = 1'b1;
        c0 = cyc + 1;
        push(c0,      V_UP,     1'b0, "up_switch_en");
        push(c0 + 6,  V_UP,     1'b0, "up_wait_sync");
        push(c0 + 22, V_UP,     1'b0, "settle_last");
        push(c0 + 23, V_CLKON,  1'b0, "clk_en_rise");
        push(c0 + 30, V_CLKON,  1'b0, "rst_hold_last");
        push(c0 + 31, V_RSTREL, 1'b0, "rst_release");
        push(c0 + 32, V_ON,     1'b0, "on_ack");
        for (int k = 0; k < 60 && sb_q.size() > 0; k++) begin
            @(negedge clk);
            if (cyc == c0 + 4) switch_ack = 1'b1;
            if (sb_q[0].at == cyc) begin
                e = sb_q.pop_front();
                nm = nm_q.pop_front();
                checks++;
                if (obs !== e.val) begin
                    failures++;
                    $display("FAIL %s cyc=%0d got=%b exp=%b", nm, cyc, obs, e.val);
                end
            end
        end
        if (sb_q.size() > 0) begin
            checks++;
            failures++;
            $display("FAIL power_up_budget pending=%0d exp=0", sb_q.size());
            sb_q.delete();
            nm_q.delete();
        end
    endtask

    task automatic test_power_down();
        exp_t e;
        string nm;
        int m;
        @(negedge clk);
        pwr_req = 1'b0;
        m = cyc;
        push(m + 1, V_ISO,    1'b0, "dn_iso_set");
        push(m + 2, V_RSTSET, 1'b0, "dn_rst_set");
        push(m + 3, V_CLKOFF, 1'b0, "dn_clk_off");
        push(m + 4, V_DN,     1'b0, "dn_switch_off");
        push(m + 8, V_DN,     1'b0, "dn_wait_sync");
        push(m + 9, V_OFF,    1'b0, "dn_off");
        for (int k = 0; k < 30 && sb_q.size() > 0; k++) begin
            @(negedge clk);
            if (cyc == m + 6) switch_ack = 1'b0;
            if (sb_q[0].at == cyc) begin
                e = sb_q.pop_front();
                nm = nm_q.pop_front();
                checks++;
                if (obs !== e.val) begin
                    failures++;
                    $display("FAIL %s cyc=%0d got=%b exp=%b", nm, cyc, obs, e.val);
                end
            end
        end
        if (sb_q.size() > 0) begin
            checks++;
            failures++;
            $display("FAIL power_down_budget pending=%0d exp=0", sb_q.size());
            sb_q.delete();
            nm_q.delete();
        end
    endtask

    task automatic test_timeout();
        exp_t e;
        string nm;
        int c0;
        @(negedge clk);
        pwr_req = 1'b1;
        c0 = cyc + 1;
        push(c0,        V_UP,  1'b0, "tmo_up");
        push(c0 + 1023, V_UP,  1'b0, "tmo_last_wait");
        push(c0 + 1024, V_DN,  1'b1, "tmo_flag");
        push(c0 + 1025, V_OFF, 1'b1, "tmo_off");
        for (int k = 0; k < 1100 && sb_q.size() > 0; k++) begin
            @(negedge clk);
            if (cyc == c0) pwr_req = 1'b0;
            if (sb_q[0].at == cyc) begin
                e = sb_q.pop_front();
                nm = nm_q.pop_front();
                checks++;
                if (obs !== e.val) begin
                    failures++;
                    $display("FAIL %s cyc=%0d got=%b exp=%b", nm, cyc, obs, e.val);
                end
            end
        end
        if (sb_q.size() > 0) begin
            checks++;
            failures++;
            $display("FAIL timeout_budget pending=%0d exp=0", sb_q.size());
            sb_q.delete();
            nm_q.delete();
        end
    endtask

    // Retry after timeout, with the request withdrawn while still settling
    task automatic test_req_drop_in_settle();
        exp_t e;
        string nm;
        int c0;
        @(negedge clk);
        pwr_req = 1'b1;
        c0 = cyc + 1;
        push(c0,      V_UP,    1'b1, "retry_up");
        push(c0 + 23, V_CLKON, 1'b1, "drop_clk_en");
        push(c0 + 32, V_ON,    1'b1, "drop_reaches_on");
        push(c0 + 33, V_ISO,   1'b1, "drop_iso_set");
        push(c0 + 36, V_DN,    1'b1, "drop_switch_off");
        push(c0 + 41, V_OFF,   1'b1, "drop_off");
        for (int k = 0; k < 60 && sb_q.size() > 0; k++) begin
            @(negedge clk);
            if (cyc == c0 + 4)  switch_ack = 1'b1;
            if (cyc == c0 + 10) pwr_req = 1'b0;
            if (cyc == c0 + 38) switch_ack = 1'b0;
            if (sb_q[0].at == cyc) begin
                e = sb_q.pop_front();
                nm = nm_q.pop_front();
                checks++;
                if (obs !== e.val) begin
                    failures++;
                    $display("FAIL %s cyc=%0d got=%b exp=%b", nm, cyc, obs, e.val);
                end
            end
        end
        if (sb_q.size() > 0) begin
            checks++;
            failures++;
            $display("FAIL req_drop_budget pending=%0d exp=0", sb_q.size());
            sb_q.delete();
            nm_q.delete();
        end
    endtask

    task automatic test_async_reset();
        exp_t e;
        string nm;
        int c0;
        @(negedge clk);
        pwr_req = 1'b1;
        c0 = cyc + 1;
        push(c0 + 23, V_CLKON, 1'b1, "ar_in_clk_on");
        for (int k = 0; k < 60 && sb_q.size() > 0; k++) begin
            @(negedge clk);
            if (cyc == c0 + 4) switch_ack = 1'b1;
            if (sb_q[0].at == cyc) begin
                e = sb_q.pop_front();
                nm = nm_q.pop_front();
                checks++;
                if (obs !== e.val) begin
                    failures++;
                    $display("FAIL %s cyc=%0d got=%b exp=%b", nm, cyc, obs, e.val);
                end
            end
        end
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        push(cyc, V_OFF, 1'b0, "ar_immediate");
        e = sb_q.pop_front();
        nm = nm_q.pop_front();
        checks++;
        if (obs !== e.val) begin
            failures++;
            $display("FAIL %s cyc=%0d got=%b exp=%b", nm, cyc, obs, e.val);
        end
        pwr_req = 1'b0;
        switch_ack = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Power down, then re-request while still in PWR_DN: must finish OFF and go straight back up
    task automatic test_back_to_back();
        exp_t e;
        string nm;
        int c0;
        @(negedge clk);
        pwr_req = 1'b1;
        c0 = cyc + 1;
        push(c0 + 32, V_ON,  1'b0, "b2b_on");
        push(c0 + 36, V_DN,  1'b0, "b2b_switch_off");
        push(c0 + 41, V_OFF, 1'b0, "b2b_off");
        push(c0 + 42, V_UP,  1'b0, "b2b_reup");
        for (int k = 0; k < 70 && sb_q.size() > 0; k++) begin
            @(negedge clk);
            if (cyc == c0 + 4)  switch_ack = 1'b1;
            if (cyc == c0 + 32) pwr_req = 1'b0;
            if (cyc == c0 + 37) pwr_req = 1'b1;
            if (cyc == c0 + 38) switch_ack = 1'b0;
            if (sb_q[0].at == cyc) begin
                e = sb_q.pop_front();
                nm = nm_q.pop_front();
                checks++;
                if (obs !== e.val) begin
                    failures++;
                    $display("FAIL %s cyc=%0d got=%b exp=%b", nm, cyc, obs, e.val);
                end
            end
        end
        if (sb_q.size() > 0) begin
            checks++;
            failures++;
            $display("FAIL back_to_back_budget pending=%0d exp=0", sb_q.size());
            sb_q.delete();
            nm_q.delete();
        end
        pwr_req = 1'b0;
    endtask

    initial begin
        test_reset();
        test_power_up();
        test_power_down();
        test_timeout();
        test_req_drop_in_settle();
        test_async_reset();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
